// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built from two half_adder cells per bit and a carry flop.
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Only WIDTH-1 partial bits are stored; the last bit goes straight to sum_out.
  logic [WIDTH-2:0] ps_q, ps_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  logic             ha0_s, ha0_c, bit_s, ha1_c, c_next;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s),  .b(c_q),    .s(bit_s), .c(ha1_c));

  assign c_next = ha0_c | ha1_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign load_b = sub_in ? ~b_in : b_in;
  assign load_c = sub_in;
`else
  assign load_b = b_in;
  assign load_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in)       state_d = RUN;
      RUN:     if (cnt_q == LAST)  state_d = DONE;
      DONE:    if (ready_in)       state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d   = a_in;
          b_d   = load_b;
          c_d   = load_c;
          cnt_d = '0;
          ps_d  = '0;
        end
      end
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        c_d  = c_next;
        ps_d = (WIDTH-1)'({bit_s, ps_q} >> 1);
        // Counter holds at LAST on the final bit so it never wraps.
        if (cnt_q == LAST) begin
          sum_d   = {bit_s, ps_q};
          carry_d = c_next;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_in) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_out = (state_q == IDLE);
    valid_out = valid_q;
    sum_out   = sum_q;
    carry_out = carry_q;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Bit-serial WIDTH-bit adder built around the team's `half_adder` cell.
- Per-bit full add: two `half_adder` instances plus an OR of their carries; a carry flip-flop links successive bits.
- Accepts a pair of operands over a ready/valid handshake, processes one bit per clock LSB-first, then presents the registered sum and final carry on a second ready/valid handshake.
- Sits directly downstream of the `half_adder` cell: a sequential wrapper that consumes its sum/carry outputs.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start_in  input  1  operand valid.
- ready_out  output  1  block can accept operands; equals (state == IDLE).
- a_in  input  WIDTH  operand A; sampled on acceptance.
- b_in  input  WIDTH  operand B; sampled on acceptance.
- sub_in  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- sum_out  output  WIDTH  result; registered.
- carry_out  output  1  final carry out of the MSB; registered.
- valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts result.

## Operation
- Reset (asynchronous assertion):
  - State → IDLE.
  - sum_out, carry_out, valid_out, internal shift registers, carry flip-flop and bit counter → 0.
  - ready_out = 1 while in reset.
  - Any in-progress operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Operands are accepted on a clock edge where start_in && ready_out.
  - On acceptance: load a_in and b_in into shift registers, clear the carry flip-flop, clear the bit counter, go to RUN.
- RUN, one bit per edge:
  - s = a[0]^b[0]^c; c' = a[0]&b[0] | c&(a[0]^b[0]).
  - s is shifted into the MSB of the partial-sum register; a and b shift right; the counter increments.
  - On the edge where counter == WIDTH-1: partial sum with s inserted → sum_out, c' → carry_out, valid_out ← 1, go to DONE.
- DONE:
  - sum_out and carry_out are held stable while valid_out = 1.
  - On an edge with ready_in = 1: valid_out ← 0, go to IDLE.
  - sum_out and carry_out keep the last result until the next completion.
- start_in is ignored in RUN and DONE.
  - No operand capture.
  - No effect on the current operation.
- Arithmetic is modulo 2^WIDTH. carry_out is bit WIDTH of a_in + b_in.
- The bit counter is $clog2(WIDTH) bits wide and never wraps within an operation.

## Timing
- Acceptance edge = edge 0.
- valid_out rises after edge WIDTH: WIDTH cycles from acceptance to result (8 for the default WIDTH).
- Minimum completion edge: valid_out && ready_in in the first DONE cycle → IDLE after edge WIDTH+1.
  - ready_out = 1 in the following cycle.
  - Next acceptance can occur at edge WIDTH+2 at the earliest.
- Throughput is one operation per WIDTH+2 cycles, with no overlap between operations.
- ready_in held low stalls indefinitely in DONE with outputs frozen.
- ready_out and valid_out are never 1 in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub_in port exists and is sampled with the operands.
  - When sub_in = 1: B is inverted on load and the carry flip-flop is initialised to 1, so the block computes a_in − b_in.
  - In subtract mode, carry_out = 1 means no borrow (a_in ≥ b_in unsigned).
- SERIAL_ADDER_SUB_EN undefined: no sub_in port, add only, carry flip-flop always initialised to 0.

## Test plan
- Basic add: WIDTH=8, a_in=8'h0F, b_in=8'h01, ready_in=1 → valid_out high exactly 8 cycles after acceptance, sum_out=8'h10, carry_out=0.
- Overflow: a_in=8'hFF, b_in=8'h01 → sum_out=8'h00, carry_out=1; a_in=8'hFF, b_in=8'hFF → sum_out=8'hFE, carry_out=1.
- Backpressure: ready_in=0 for 5 cycles after valid_out rises → valid_out, sum_out, carry_out stable; ready_out=0 throughout; state returns to IDLE one edge after ready_in=1.
- Busy ignore: start_in=1 with a_in=8'hAA, b_in=8'h55 pulsed during RUN of 8'h03+8'h04 → result is 8'h07, carry_out=0; no second result is produced.
- Reset mid-operation: rst_n low at bit 4 of RUN → all outputs 0 and ready_out=1 immediately; a fresh 8'h01+8'h01 afterwards gives 8'h02.
- Subtract (SERIAL_ADDER_SUB_EN): sub_in=1, 8'h05−8'h07 → sum_out=8'hFE, carry_out=0; 8'h07−8'h05 → 8'h02, carry_out=1.
